// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer: op codes, FSM states
// and the fixed iteration count of the radix-2 algorithms.
package muldiv_pkg;

  localparam int ITERATIONS = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage <-> multiply/divide sequencer bundle, plus FSM state for debug.
interface muldiv_sequencer_if;
  import muldiv_pkg::*;

  // start is a single-cycle request: it is taken only when the sequencer is
  // idle and no flush is present; otherwise stall stays high and execute must
  // hold start (and any MTHI/MTLO/MFHI/MFLO) until stall drops.
  logic        start;
  op_e         op;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        flush;
  logic        writeHi;
  logic        writeLo;
  logic [31:0] writeData;
  logic        readHiLo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        divByZero;
  logic        stall;
  state_e      dbg_state;

  modport master (
    output start, op, operandA, operandB, flush, writeHi, writeLo, writeData, readHiLo,
    input  hi, lo, busy, done, divByZero, stall, dbg_state
  );

  modport slave (
    input  start, op, operandA, operandB, flush, writeHi, writeLo, writeData, readHiLo,
    output hi, lo, busy, done, divByZero, stall, dbg_state
  );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a 64-bit
// accumulator. Multiply keeps the multiplier in the low half; divide keeps the
// partial remainder high and builds the quotient low.
module muldiv_step (
  input  logic        i_is_div,
  input  logic [63:0] i_acc,
  input  logic [31:0] i_operand,
  output logic [63:0] o_acc
);

  logic [32:0] w_sum;
  logic [32:0] w_rem;
  logic        w_ge;
  logic [31:0] w_diff;

  always_comb begin
    w_sum  = {1'b0, i_acc[63:32]} + {1'b0, i_operand};
    // Shifted remainder needs 33 bits; the difference always fits in 32.
    w_rem  = i_acc[63:31];
    w_ge   = (w_rem >= {1'b0, i_operand});
    w_diff = i_acc[62:31] - i_operand;
    o_acc  = i_acc;
    if (i_is_div) begin
      if (w_ge) o_acc = {w_diff, i_acc[30:0], 1'b1};
      else      o_acc = {i_acc[62:0], 1'b0};
    end else if (i_acc[0]) begin
      o_acc = {w_sum, i_acc[31:1]};
    end else begin
      o_acc = {1'b0, i_acc[63:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO owner beside the execute ALU: 32-step multiply/divide with sign fixup,
// MTHI/MTLO writes and a stall for any HI/LO access while an op is in flight.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  muldiv_sequencer_if.slave bus
);

  state_e           r_state;
  logic [CNT_W-1:0] r_count;
  op_e              r_op;
  logic             r_sign_a;
  logic             r_neg;
  logic [63:0]      r_acc;
  logic [31:0]      r_operand;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic             w_signed;
  logic             w_is_div;
  logic [31:0]      w_abs_a;
  logic [31:0]      w_abs_b;
  logic             w_accept;
  logic [63:0]      w_step_acc;
  logic [31:0]      w_fix_hi;
  logic [31:0]      w_fix_lo;
  logic [63:0]      w_prod;

  assign w_signed = op_is_signed(bus.op);
  assign w_is_div = op_is_div(bus.op);
  assign w_abs_a  = (w_signed && bus.operandA[31]) ? (~bus.operandA + 32'd1) : bus.operandA;
  assign w_abs_b  = (w_signed && bus.operandB[31]) ? (~bus.operandB + 32'd1) : bus.operandB;
  assign w_accept = bus.start && !bus.flush && (r_state == IDLE);

  muldiv_step u_step (
    .i_is_div  (op_is_div(r_op)),
    .i_acc     (r_acc),
    .i_operand (r_operand),
    .o_acc     (w_step_acc)
  );

  // Quotient sign follows operand sign mismatch; remainder follows the dividend.
  always_comb begin
    w_prod   = r_neg ? (~r_acc + 64'd1) : r_acc;
    w_fix_hi = w_prod[63:32];
    w_fix_lo = w_prod[31:0];
    if (op_is_div(r_op)) begin
      w_fix_lo = r_neg    ? (~r_acc[31:0]  + 32'd1) : r_acc[31:0];
      w_fix_hi = r_sign_a ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_op      <= MULTU;
      r_sign_a  <= 1'b0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_operand <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state   <= CALC;
            r_busy    <= 1'b1;
            r_count   <= '0;
            r_op      <= bus.op;
            r_sign_a  <= w_signed & bus.operandA[31];
            r_neg     <= w_signed & (bus.operandA[31] ^ bus.operandB[31]);
            r_dbz     <= w_is_div && (bus.operandB == 32'd0);
            r_acc     <= {32'd0, w_is_div ? w_abs_a : w_abs_b};
            r_operand <= w_is_div ? w_abs_b : w_abs_a;
          end else if (!bus.start) begin
            if (bus.writeHi) r_hi <= bus.writeData;
            if (bus.writeLo) r_lo <= bus.writeData;
          end
        end
        CALC: begin
          if (bus.flush) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_count <= '0;
          end else begin
            r_acc   <= w_step_acc;
            r_count <= r_count + 1'b1;
            if (r_count == CNT_W'(ITERATIONS - 1)) r_state <= FIXUP;
          end
        end
        FIXUP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_count <= '0;
          if (!bus.flush) begin
            r_hi   <= w_fix_hi;
            r_lo   <= w_fix_lo;
            r_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.divByZero = r_dbz;
  assign bus.dbg_state = r_state;
  assign bus.stall     = r_busy && (bus.start || bus.readHiLo || bus.writeHi || bus.writeLo);

endmodule
